// File: rtl/trace_capture.sv
// Acquisition front end for the scope trace RAM: decimates ADC samples, waits
// for a level trigger (or force/auto timeout), then writes one frame of screen Y values.
module trace_capture #(
  parameter int DEPTH   = 640,
  parameter int AW      = 10,
  parameter int DW      = 9,
  parameter int SW      = 12,
  parameter int AUTO_TO = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid,
  input  logic [SW-1:0] sample,
  input  logic [15:0]   decim,
  input  logic [8:0]    trig_level,
  input  logic          trig_rising,
  input  logic          auto_mode,
  input  logic          arm,
  input  logic          force_trig,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done
);

  localparam int TW = $clog2(AUTO_TO);
  localparam logic [8:0] Y_MAX = 9'd479;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRIG,
    CAPTURE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   dcnt_q, dcnt_d;
  logic [TW-1:0] tocnt_q, tocnt_d;
  logic [8:0]    prev_s9_q, prev_s9_d;
  logic          have_prev_q, have_prev_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [8:0] s9;
  logic [8:0] y9;
  logic       tick;
  logic       arm_ok;
  logic       edge_hit;
  logic       auto_hit;

  always_comb begin
    s9       = 9'(sample >> (SW - 9));
    y9       = (s9 > Y_MAX) ? 9'd0 : (Y_MAX - s9);
    tick     = sample_valid && (dcnt_q == 16'd0);
    arm_ok   = arm && ((state_q == IDLE) || (state_q == DONE));
    edge_hit = have_prev_q &&
               (trig_rising ? ((prev_s9_q < trig_level) && (s9 >= trig_level))
                            : ((prev_s9_q >= trig_level) && (s9 < trig_level)));
    auto_hit = auto_mode && (tocnt_q == TW'(AUTO_TO - 1));
  end

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    tocnt_d     = tocnt_q;
    prev_s9_d   = prev_s9_q;
    have_prev_d = have_prev_q;
    wptr_d      = wptr_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    // Decimator free-runs; a fresh arm restarts it so the next valid sample is a tick.
    if (arm_ok) begin
      dcnt_d = 16'd0;
    end else if (sample_valid) begin
      dcnt_d = tick ? decim : (dcnt_q - 16'd1);
    end

    case (state_q)
      IDLE, DONE: begin
        if (arm_ok) begin
          state_d     = WAIT_TRIG;
          have_prev_d = 1'b0;
          tocnt_d     = '0;
        end
      end
      WAIT_TRIG: begin
        if (tick) begin
          prev_s9_d   = s9;
          have_prev_d = 1'b1;
          tocnt_d     = tocnt_q + TW'(1);
        end
        if (force_trig || (tick && (edge_hit || auto_hit))) begin
          state_d = CAPTURE;
          wptr_d  = '0;
          if (tick) begin
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = DW'(y9);
            wptr_d  = AW'(1);
          end
        end
      end
      CAPTURE: begin
        if (tick) begin
          we_d    = 1'b1;
          waddr_d = wptr_q;
          wdata_d = DW'(y9);
          if (wptr_q == AW'(DEPTH - 1)) begin
            state_d = DONE;
          end else begin
            wptr_d = wptr_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WAIT_TRIG) || (state_d == CAPTURE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      tocnt_q     <= '0;
      prev_s9_q   <= '0;
      have_prev_q <= 1'b0;
      wptr_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      tocnt_q     <= tocnt_d;
      prev_s9_q   <= prev_s9_d;
      have_prev_q <= have_prev_d;
      wptr_q      <= wptr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
